// File: rtl/mmio_fabric_if.sv
// Bus bundle between the CPU-side MMIO controller, the fabric and its peripherals.
// The fabric uses the slave modport; the CPU/peripheral environment uses master.
interface mmio_fabric_if #(
  parameter int unsigned SLOTS      = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SLOT_SHIFT = 4
);
  logic                    req;
  logic                    we;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       wdata;
  logic                    ready;
  logic [DATA_W-1:0]       rdata;
  logic                    err;
  logic [SLOTS-1:0]        p_sel;
  logic                    p_we;
  logic [SLOT_SHIFT-1:0]   p_addr;
  logic [DATA_W-1:0]       p_wdata;
  logic [SLOTS*DATA_W-1:0] p_rdata;
  logic [SLOTS-1:0]        p_ack;

  modport master (
    output req, we, addr, wdata, p_rdata, p_ack,
    input  ready, rdata, err, p_sel, p_we, p_addr, p_wdata
  );

  modport slave (
    input  req, we, addr, wdata, p_rdata, p_ack,
    output ready, rdata, err, p_sel, p_we, p_addr, p_wdata
  );
endinterface

// File: rtl/mmio_fabric.sv
// Memory-mapped peripheral fabric: decodes an access into one of SLOTS windows and runs a req/ack handshake.
// Define MMIO_FABRIC_TIMEOUT_EN to abort unresponsive peripherals after TIMEOUT access cycles.
module mmio_fabric #(
  parameter int unsigned       SLOTS      = 8,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       SLOT_SHIFT = 4,
  parameter logic [ADDR_W-1:0] BASE       = 16'hFF00,
  parameter int unsigned       TIMEOUT    = 15
) (
  input  logic          CLK,
  input  logic          RST,
  mmio_fabric_if.slave  bus
);
  localparam int unsigned       SLOT_W       = $clog2(SLOTS);
  localparam int unsigned       REGION_WORDS = SLOTS << SLOT_SHIFT;
  localparam logic [ADDR_W-1:0] REGION_MASK  = ADDR_W'(REGION_WORDS - 1);

  // Elaboration-time parameter sanity checks
  if ((SLOTS < 2) || ((SLOTS & (SLOTS - 1)) != 0)) begin : g_bad_slots
    $error("mmio_fabric: SLOTS must be a power of two, at least 2");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mmio_fabric: TIMEOUT must be in 1..255");
  end
  if ((BASE & REGION_MASK) != '0) begin : g_bad_base
    $error("mmio_fabric: BASE must be aligned to the region size");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                r_state;
  logic [SLOT_W-1:0]     r_slot;
  logic                  r_ready;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [SLOTS-1:0]      r_sel;
  logic                  r_we;
  logic [SLOT_SHIFT-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;

`ifdef MMIO_FABRIC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]            r_cnt;
`endif

  logic                  w_in_region;
  logic [SLOT_W-1:0]     w_slot;
  logic                  w_ack;
  logic [DATA_W-1:0]     w_sel_rdata;

  assign w_in_region = ((bus.addr & ~REGION_MASK) == BASE);
  assign w_slot      = bus.addr[SLOT_SHIFT +: SLOT_W];
  assign w_ack       = bus.p_ack[r_slot];

  // Read-data mux for the latched slot
  always_comb begin
    w_sel_rdata = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (r_slot == SLOT_W'(k)) w_sel_rdata = bus.p_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef MMIO_FABRIC_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_slot  <= w_slot;
            r_we    <= bus.we;
            r_addr  <= bus.addr[SLOT_SHIFT-1:0];
            r_wdata <= bus.wdata;
            if (w_in_region) begin
              r_sel   <= SLOTS'(1) << w_slot;
              r_state <= S_ACCESS;
`ifdef MMIO_FABRIC_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end else begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          // Only the selected slot's ack counts; stray acks are ignored
          if (w_ack) begin
            r_sel   <= '0;
            r_rdata <= r_we ? '0 : w_sel_rdata;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end
`ifdef MMIO_FABRIC_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready   = r_ready;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
  assign bus.p_sel   = r_sel;
  assign bus.p_we    = r_we;
  assign bus.p_addr  = r_addr;
  assign bus.p_wdata = r_wdata;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed testbench for mmio_fabric: reset, hits, wait states, misses, silent slot, stray acks, back-to-back.
`timescale 1ns/1ps
module tb_mmio_fabric;
  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  mmio_fabric_if #(.SLOTS(8), .DATA_W(16), .ADDR_W(16), .SLOT_SHIFT(4)) bus ();

  mmio_fabric #(
    .SLOTS(8), .DATA_W(16), .ADDR_W(16), .SLOT_SHIFT(4), .BASE(16'hFF00), .TIMEOUT(15)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1 ns after the next rising edge: inputs change and outputs are sampled here
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_rdata(input int slot, input logic [15:0] val);
    bus.p_rdata[slot*16 +: 16] = val;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'hFF23; bus.wdata = 16'hA5A5;
    tick(); tick();
    checks++; if (bus.ready !== 1'b0)     begin failures++; $display("FAIL rst_ready got=%0h exp=0", bus.ready); end
    checks++; if (bus.rdata !== 16'h0)    begin failures++; $display("FAIL rst_rdata got=%0h exp=0", bus.rdata); end
    checks++; if (bus.err !== 1'b0)       begin failures++; $display("FAIL rst_err got=%0h exp=0", bus.err); end
    checks++; if (bus.p_sel !== 8'h00)    begin failures++; $display("FAIL rst_p_sel got=%0h exp=0", bus.p_sel); end
    checks++; if (bus.p_we !== 1'b0)      begin failures++; $display("FAIL rst_p_we got=%0h exp=0", bus.p_we); end
    checks++; if (bus.p_addr !== 4'h0)    begin failures++; $display("FAIL rst_p_addr got=%0h exp=0", bus.p_addr); end
    checks++; if (bus.p_wdata !== 16'h0)  begin failures++; $display("FAIL rst_p_wdata got=%0h exp=0", bus.p_wdata); end
    bus.req = 1'b0; bus.we = 1'b0; RST = 1'b0;
    tick();
    // Reset in the middle of an access
    bus.req = 1'b1; bus.addr = 16'hFF23;
    tick();
    checks++; if (bus.p_sel !== 8'h04)    begin failures++; $display("FAIL midrst_sel_before got=%0h exp=04", bus.p_sel); end
    bus.req = 1'b0;
    #3 RST = 1'b1;
    #1;
    checks++; if (bus.p_sel !== 8'h00)    begin failures++; $display("FAIL midrst_sel_async got=%0h exp=00", bus.p_sel); end
    tick(); tick();
    RST = 1'b0; bus.p_ack = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.ready !== 1'b0)   begin failures++; $display("FAIL midrst_no_ready cyc=%0d got=%0h exp=0", i, bus.ready); end
    end
    bus.p_ack = 8'h00;
  endtask

  task automatic test_read_hit();
    set_rdata(2, 16'hBEEF);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFF23;
    tick();
    checks++; if (bus.p_sel !== 8'b00000100) begin failures++; $display("FAIL hit_p_sel got=%0h exp=04", bus.p_sel); end
    checks++; if (bus.p_addr !== 4'd3)       begin failures++; $display("FAIL hit_p_addr got=%0h exp=3", bus.p_addr); end
    checks++; if (bus.ready !== 1'b0)        begin failures++; $display("FAIL hit_early_ready got=%0h exp=0", bus.ready); end
    bus.req = 1'b0; bus.p_ack = 8'h04;
    tick();
    checks++; if (bus.ready !== 1'b1)        begin failures++; $display("FAIL hit_ready got=%0h exp=1", bus.ready); end
    checks++; if (bus.rdata !== 16'hBEEF)    begin failures++; $display("FAIL hit_rdata got=%0h exp=beef", bus.rdata); end
    checks++; if (bus.err !== 1'b0)          begin failures++; $display("FAIL hit_err got=%0h exp=0", bus.err); end
    checks++; if (bus.p_sel !== 8'h00)       begin failures++; $display("FAIL hit_sel_drop got=%0h exp=0", bus.p_sel); end
    bus.p_ack = 8'h00;
    tick();
    checks++; if (bus.ready !== 1'b0)        begin failures++; $display("FAIL hit_ready_pulse got=%0h exp=0", bus.ready); end
    checks++; if (bus.rdata !== 16'hBEEF)    begin failures++; $display("FAIL hit_rdata_hold got=%0h exp=beef", bus.rdata); end
  endtask

  task automatic test_unmapped();
    logic [15:0] addrs [2];
    addrs[0] = 16'hFF80; addrs[1] = 16'h0100;
    for (int i = 0; i < 2; i++) begin
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = addrs[i];
      tick();
      checks++; if (bus.ready !== 1'b1)   begin failures++; $display("FAIL miss_ready addr=%0h got=%0h exp=1", addrs[i], bus.ready); end
      checks++; if (bus.err !== 1'b1)     begin failures++; $display("FAIL miss_err addr=%0h got=%0h exp=1", addrs[i], bus.err); end
      checks++; if (bus.rdata !== 16'h0)  begin failures++; $display("FAIL miss_rdata addr=%0h got=%0h exp=0", addrs[i], bus.rdata); end
      checks++; if (bus.p_sel !== 8'h00)  begin failures++; $display("FAIL miss_p_sel addr=%0h got=%0h exp=0", addrs[i], bus.p_sel); end
      bus.req = 1'b0;
      tick();
      checks++; if (bus.ready !== 1'b0 || bus.p_sel !== 8'h00) begin
        failures++; $display("FAIL miss_after addr=%0h ready=%0h sel=%0h exp ready=0 sel=0", addrs[i], bus.ready, bus.p_sel);
      end
    end
  endtask

  task automatic test_write_wait();
    set_rdata(7, 16'hAAAA);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'hFF71; bus.wdata = 16'h1234;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.req = 1'b0; bus.wdata = 16'h0000;
      checks++; if (bus.p_sel !== 8'h80)      begin failures++; $display("FAIL wr_p_sel cyc=%0d got=%0h exp=80", k, bus.p_sel); end
      checks++; if (bus.p_we !== 1'b1)        begin failures++; $display("FAIL wr_p_we cyc=%0d got=%0h exp=1", k, bus.p_we); end
      checks++; if (bus.p_wdata !== 16'h1234) begin failures++; $display("FAIL wr_p_wdata cyc=%0d got=%0h exp=1234", k, bus.p_wdata); end
      checks++; if (bus.ready !== 1'b0)       begin failures++; $display("FAIL wr_early_ready cyc=%0d got=%0h exp=0", k, bus.ready); end
      if (k == 4) bus.p_ack = 8'h80;
    end
    tick();
    checks++; if (bus.ready !== 1'b1)    begin failures++; $display("FAIL wr_ready got=%0h exp=1", bus.ready); end
    checks++; if (bus.rdata !== 16'h0)   begin failures++; $display("FAIL wr_rdata got=%0h exp=0", bus.rdata); end
    checks++; if (bus.err !== 1'b0)      begin failures++; $display("FAIL wr_err got=%0h exp=0", bus.err); end
    bus.p_ack = 8'h00; bus.we = 1'b0;
    tick();
  endtask

  task automatic test_silent_slot();
    set_rdata(5, 16'h5555);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFF50;
`ifdef MMIO_FABRIC_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      tick();
      bus.req = 1'b0;
      checks++; if (bus.ready !== 1'b0 || bus.p_sel !== 8'h20) begin
        failures++; $display("FAIL to_wait cyc=%0d ready=%0h sel=%0h exp ready=0 sel=20", k, bus.ready, bus.p_sel);
      end
    end
    tick();
    checks++; if (bus.ready !== 1'b1)    begin failures++; $display("FAIL to_ready got=%0h exp=1", bus.ready); end
    checks++; if (bus.err !== 1'b1)      begin failures++; $display("FAIL to_err got=%0h exp=1", bus.err); end
    checks++; if (bus.rdata !== 16'h0)   begin failures++; $display("FAIL to_rdata got=%0h exp=0", bus.rdata); end
    checks++; if (bus.p_sel !== 8'h00)   begin failures++; $display("FAIL to_sel_drop got=%0h exp=0", bus.p_sel); end
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.req = 1'b0;
      checks++; if (bus.ready !== 1'b0 || bus.p_sel !== 8'h20) begin
        failures++; $display("FAIL wait_forever cyc=%0d ready=%0h sel=%0h exp ready=0 sel=20", k, bus.ready, bus.p_sel);
      end
    end
    bus.p_ack = 8'h20;
    tick();
    checks++; if (bus.ready !== 1'b1)     begin failures++; $display("FAIL late_ack_ready got=%0h exp=1", bus.ready); end
    checks++; if (bus.rdata !== 16'h5555) begin failures++; $display("FAIL late_ack_rdata got=%0h exp=5555", bus.rdata); end
    checks++; if (bus.err !== 1'b0)       begin failures++; $display("FAIL late_ack_err got=%0h exp=0", bus.err); end
    bus.p_ack = 8'h00;
`endif
    tick();
  endtask

  task automatic test_stray_ack();
    bus.p_ack = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.ready !== 1'b0 || bus.p_sel !== 8'h00) begin
        failures++; $display("FAIL stray_idle cyc=%0d ready=%0h sel=%0h exp ready=0 sel=0", i, bus.ready, bus.p_sel);
      end
    end
    set_rdata(0, 16'hDEAD); set_rdata(1, 16'h1111); set_rdata(3, 16'hCAFE);
    bus.req = 1'b1; bus.addr = 16'hFF10; bus.p_ack = 8'hFD;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (bus.ready !== 1'b0 || bus.p_sel !== 8'h02) begin
        failures++; $display("FAIL stray_access cyc=%0d ready=%0h sel=%0h exp ready=0 sel=02", k, bus.ready, bus.p_sel);
      end
    end
    bus.p_ack = 8'h02;
    tick();
    checks++; if (bus.ready !== 1'b1)     begin failures++; $display("FAIL stray_ready got=%0h exp=1", bus.ready); end
    checks++; if (bus.rdata !== 16'h1111) begin failures++; $display("FAIL stray_rdata got=%0h exp=1111", bus.rdata); end
    bus.req = 1'b0; bus.p_ack = 8'h00;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ready;
    logic [7:0] exp_sel [6];
    exp_ready = 6'b010010;
    exp_sel[0] = 8'h04; exp_sel[1] = 8'h00; exp_sel[2] = 8'h00;
    exp_sel[3] = 8'h04; exp_sel[4] = 8'h00; exp_sel[5] = 8'h00;
    set_rdata(2, 16'h7E57);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hFF23; bus.p_ack = 8'h04;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 4) bus.req = 1'b0;
      checks++; if (bus.ready !== exp_ready[5-c] || bus.p_sel !== exp_sel[c]) begin
        failures++; $display("FAIL b2b cyc=%0d ready=%0h sel=%0h exp ready=%0h sel=%0h", c + 1, bus.ready, bus.p_sel, exp_ready[5-c], exp_sel[c]);
      end
    end
    checks++; if (bus.rdata !== 16'h7E57) begin failures++; $display("FAIL b2b_rdata got=%0h exp=7e57", bus.rdata); end
    bus.p_ack = 8'h00;
  endtask

  initial begin
    checks = 0; failures = 0;
    RST = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.p_rdata = '0; bus.p_ack = '0;
    test_reset();
    test_read_hit();
    test_unmapped();
    test_write_wait();
    test_silent_slot();
    test_stray_ack();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_fabric.md
# mmio_fabric

Parametrised memory-mapped peripheral fabric that replaces the fixed one-hot peripheral select/mux in the top level. It decodes a CPU-side access into one of `SLOTS` peripheral windows, runs a request/acknowledge handshake with that peripheral, registers the read data, and reports a bus error for unmapped addresses or unresponsive peripherals. It sits between the RAM/MMIO controller and the peripherals (status, stacks, UART, GPIO, and later additions).

## Interface
Parameters:
- `SLOTS`, 8: number of peripheral windows; power of two, at least 2.
- `DATA_W`, 16: data width.
- `ADDR_W`, 16: CPU address width.
- `SLOT_SHIFT`, 4: log2 of the words per window.
- `BASE`, 16'hFF00: region base address; must be aligned to `SLOTS << SLOT_SHIFT`.
- `TIMEOUT`, 15: maximum number of ACCESS cycles to wait for an ack; range 1 to 255.

Ports (clock and reset first):
- `CLK`  in  1: the single system clock; all state changes on its rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `req`  in  1: access request; sampled only in IDLE.
- `we`  in  1: 1 = write, 0 = read.
- `addr`  in  ADDR_W: word address.
- `wdata`  in  DATA_W: write data.
- `ready`  out  1: one-cycle response strobe.
- `rdata`  out  DATA_W: read data; valid while `ready`.
- `err`  out  1: error flag; valid while `ready`.
- `p_sel`  out  SLOTS: one-hot peripheral select.
- `p_we`  out  1: peripheral write enable.
- `p_addr`  out  SLOT_SHIFT: word offset within the window.
- `p_wdata`  out  DATA_W: peripheral write data.
- `p_rdata`  in  SLOTS*DATA_W: flattened read data; slot k occupies bits `[k*DATA_W +: DATA_W]`.
- `p_ack`  in  SLOTS: per-slot acknowledge.

## Operation
The fabric is a three-state FSM: IDLE, ACCESS, RESP.

**Decode**
- An address is in region when `(addr & ~(SLOTS*2^SLOT_SHIFT - 1)) == BASE`.
- slot = `addr[SLOT_SHIFT +: log2(SLOTS)]`.
- offset = `addr[SLOT_SHIFT-1:0]`.

**IDLE**
- On `req`, latch `we`, slot, offset and `wdata`.
- In region → ACCESS, with the timeout counter cleared.
- Out of region → RESP with `err`=1 and `rdata`=0.

**ACCESS**
- `p_sel[slot]`=1, and `p_we`, `p_addr`, `p_wdata` are driven from the latched values; all are held stable for the whole state.
- On `p_ack[slot]`: capture `p_rdata` of that slot (0 for writes), set `err`=0, go to RESP.
- Ack bits from non-selected slots are ignored.
- The counter increments on every ACCESS cycle without an ack.

**RESP**
- `ready`=1 for exactly one cycle, then IDLE.
- `rdata` and `err` hold their values until the next RESP.

**Other rules**
- `req` asserted outside IDLE is ignored. The CPU must deassert `req` or issue the next request after `ready`.
- A `req` held high across RESP starts a new access in the following IDLE cycle.
- `p_ack` seen in IDLE or RESP is ignored.

## Timing
- Reset values: state=IDLE, `ready`=0, `rdata`=0, `err`=0, `p_sel`=0, `p_we`=0, `p_addr`=0, `p_wdata`=0, counter=0.
- Reset asserted mid-access: `p_sel` drops immediately (asynchronously), no `ready` is issued, and the transaction is lost.
- Hit latency, ack in the first ACCESS cycle: `req` at cycle 0 → `p_sel` at cycle 1 → `ready` at cycle 2.
- Each additional cycle before the ack adds one cycle of latency.
- Miss latency: `req` at cycle 0 → `ready`=1 with `err`=1 at cycle 1.
- Minimum spacing between accesses is 3 cycles for a hit and 2 for a miss.
- All outputs are registered or decoded from state only; no combinational path from `p_ack` to `ready`.

## Configuration
`MMIO_FABRIC_TIMEOUT_EN`:
- **Defined:** an ACCESS cycle with counter == `TIMEOUT-1` and no ack goes to RESP with `err`=1 and `rdata`=0. `p_sel` drops in RESP, so the timeout response arrives `TIMEOUT+1` cycles after `req`.
- **Not defined:** no counter exists and ACCESS waits indefinitely for the ack. `err` is then raised only for out-of-region addresses.

## Test plan
- **Reset:** hold `RST`=1 with `req`=1 → all outputs 0. Assert `RST` during ACCESS → `p_sel`=0 in the same cycle and no `ready` follows.
- **Read hit:** `addr`=16'hFF23, `we`=0, slot 2 acks immediately with 16'hBEEF → `p_sel`=8'b00000100 and `p_addr`=3 at cycle 1; `ready`=1, `rdata`=16'hBEEF, `err`=0 at cycle 2.
- **Write with wait states:** `addr`=16'hFF71, `we`=1, `wdata`=16'h1234, slot 7 acks on its 4th ACCESS cycle → `p_we`=1 and `p_wdata`=16'h1234 held 4 cycles; `ready` 5 cycles after `req`; `rdata`=0, `err`=0.
- **Unmapped:** `addr`=16'hFF80, then 16'h0100 → each gives `ready` and `err`=1 one cycle after `req`, with `p_sel` never asserted.
- **Timeout** (macro defined, `TIMEOUT`=15): slot 5 never acks → `ready` with `err`=1 and `rdata`=0 at cycle 16.
- **Stray ack and back-to-back:** `p_ack`=8'hFF in IDLE and during an ACCESS to slot 1 with slot 1 silent → no early `ready`. `req` held continuously → a new access begins in the IDLE cycle after each RESP.
